mem_lrsc_arbiter: RTL and testbench

- Shares one memory port between two core datapath/cache request channels.
- Round-robin arbitration; one transaction outstanding at a time.
- Keeps a per-core LR/SC reservation (load-reserved / store-conditional) and resolves each SC against it.
- Sits between the per-core cache request logic and the single RAM/bus port.

---
 rtl/mem_lrsc_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_lrsc_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lrsc_arbiter.sv
// Two-core round-robin arbiter onto a single memory port, one transaction at a time,
// with per-core load-reserved / store-conditional reservation tracking.
module mem_lrsc_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        req_ren,
  input  logic [1:0]        req_wen,
  input  logic [1:0]        req_lr,
  input  logic [1:0]        req_sc,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam int WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg, state_next;
  logic                last_grant_reg, last_grant_next;
  logic                grant_reg, grant_next;
  logic                write_reg, write_next;
  logic                lr_reg, lr_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   result_reg, result_next;
  logic [1:0]          link_valid_reg, link_valid_next;
  logic [WORD_W-1:0]   link_addr_reg [2];
  logic [WORD_W-1:0]   link_addr_next [2];

  logic [1:0]          pending;
  logic                sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [WORD_W-1:0]   sel_word;
  logic [WORD_W-1:0]   acc_word;
  logic                sel_sc;
  logic                sc_ok;
  logic [1:0]          link_hit;

  assign pending   = req_ren | req_wen;
  // With both cores pending the one that did not win last time goes first.
  assign sel       = (pending == 2'b11) ? ~last_grant_reg : pending[1];
  assign sel_addr  = sel ? req_addr1 : req_addr0;
  assign sel_wdata = sel ? req_wdata1 : req_wdata0;
  assign sel_word  = sel_addr[ADDR_W-1:2];
  assign sel_sc    = req_sc[sel] & req_wen[sel];
  assign sc_ok     = link_valid_reg[sel] && (link_addr_reg[sel] == sel_word);
  assign acc_word  = addr_reg[ADDR_W-1:2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_link_hit
    assign link_hit[gi] = (link_addr_reg[gi] == acc_word);
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    write_next      = write_reg;
    lr_next         = lr_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    result_next     = result_reg;
    link_valid_next = link_valid_reg;
    link_addr_next  = link_addr_reg;
    case (state_reg)
      IDLE: begin
        if (|pending) begin
          grant_next      = sel;
          last_grant_next = sel;
          addr_next       = sel_addr;
          wdata_next      = sel_wdata;
          write_next      = req_wen[sel];
          lr_next         = req_lr[sel] & req_ren[sel];
          if (sel_sc && !sc_ok) begin
            // Failed SC never touches memory; answer immediately and drop the link.
            result_next          = DATA_W'(1);
            link_valid_next[sel] = 1'b0;
            state_next           = RESP;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (ram_ready) begin
          if (write_reg) begin
            result_next     = '0;
            link_valid_next = link_valid_reg & ~link_hit;
          end else begin
            result_next = ram_rdata;
            if (lr_reg) begin
              link_valid_next[grant_reg] = 1'b1;
              link_addr_next[grant_reg]  = acc_word;
            end
          end
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      write_reg      <= 1'b0;
      lr_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      result_reg     <= '0;
      link_valid_reg <= '0;
      link_addr_reg  <= '{default: '0};
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      write_reg      <= write_next;
      lr_reg         <= lr_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      result_reg     <= result_next;
      link_valid_reg <= link_valid_next;
      link_addr_reg  <= link_addr_next;
    end
  end

  // All outputs decode from registered state, so an async reset clears them at once.
  assign ram_ren   = (state_reg == ACCESS) && !write_reg;
  assign ram_wen   = (state_reg == ACCESS) && write_reg;
  assign ram_addr  = (state_reg == ACCESS) ? addr_reg : '0;
  assign ram_wdata = ((state_reg == ACCESS) && write_reg) ? wdata_reg : '0;
  assign ack       = (state_reg == RESP) ? (grant_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rdata     = (state_reg == RESP) ? result_reg : '0;

endmodule

// File: tb/tb_mem_lrsc_arbiter.sv
// Bench for mem_lrsc_arbiter: directed LR/SC/arbitration/reset steps followed by random
// rounds, checked against a transaction-level model of arbitration, links and memory.
module tb_mem_lrsc_arbiter;

  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_LR = 2;
  localparam int OP_SC = 3;

  logic        CLK;
  logic        nRST;
  logic [1:0]  req_ren, req_wen, req_lr, req_sc;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ready;

  mem_lrsc_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_lr(req_lr), .req_sc(req_sc),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .ack(ack), .rdata(rdata),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  // Memory environment (responder side)
  int          wait_fixed = 0;
  int          proto_err = 0;
  int          acc_count = 0;
  int          ren_cycles = 0;
  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [31:0] env_mem [logic [29:0]];

  // Reference model state
  logic [31:0] ref_mem [logic [29:0]];
  bit          ref_lv [2];
  logic [29:0] ref_la [2];
  int          ref_last;

  function automatic logic [31:0] mem_init(input logic [29:0] w);
    return {w[13:0], 2'b10, ~w[15:0]};
  endfunction

  function automatic logic [31:0] env_rd(input logic [29:0] w);
    return env_mem.exists(w) ? env_mem[w] : mem_init(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: configurable wait states, real storage, protocol monitoring.
  initial begin
    logic        in_acc;
    int          wcnt, target;
    logic [31:0] first_addr, first_wdata;
    logic        first_wen;
    in_acc = 1'b0; wcnt = 0; target = 0;
    first_addr = '0; first_wdata = '0; first_wen = 1'b0;
    ram_ready = 1'b0;
    ram_rdata = '0;
    env_mem[30'h40] = 32'hDEADBEEF;
    forever begin
      @(posedge CLK); #1;
      if (!nRST || ram_ready) begin
        ram_ready = 1'b0;
        in_acc    = 1'b0;
      end else if (ram_ren || ram_wen) begin
        if (ram_ren && ram_wen) proto_err++;
        if (!in_acc) begin
          in_acc      = 1'b1;
          wcnt        = 0;
          target      = (wait_fixed < 0) ? int'($urandom_range(0, 2)) : wait_fixed;
          first_addr  = ram_addr;
          first_wdata = ram_wdata;
          first_wen   = ram_wen;
        end else if (ram_addr !== first_addr || ram_wdata !== first_wdata || ram_wen !== first_wen) begin
          proto_err++;
        end
        if (ram_ren) ren_cycles++;
        if (wcnt == target) begin
          ram_ready = 1'b1;
          acc_count++;
          acc_write = ram_wen;
          acc_addr  = ram_addr;
          acc_wdata = ram_wdata;
          if (ram_wen) env_mem[ram_addr[31:2]] = ram_wdata;
          else         ram_rdata = env_rd(ram_addr[31:2]);
        end else begin
          wcnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  // Transaction-level effect of one granted request on memory and links.
  task automatic model_exec(input int core, input int op, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] er, output int em);
    logic [29:0] w;
    bit do_write;
    w = addr[31:2];
    do_write = 1'b0;
    er = '0;
    em = 0;
    case (op)
      OP_RD: begin er = ref_rd(w); em = 1; end
      OP_LR: begin er = ref_rd(w); em = 1; ref_lv[core] = 1'b1; ref_la[core] = w; end
      OP_WR: do_write = 1'b1;
      default: begin
        if (ref_lv[core] && ref_la[core] == w) do_write = 1'b1;
        else begin er = 32'd1; em = 0; ref_lv[core] = 1'b0; end
      end
    endcase
    if (do_write) begin
      ref_mem[w] = wdata;
      for (int i = 0; i < 2; i++) if (ref_la[i] == w) ref_lv[i] = 1'b0;
      er = '0;
      em = 2;
    end
  endtask

  task automatic drive_core(input int c, input int op, input logic [31:0] a, input logic [31:0] d);
    req_ren[c] = (op == OP_RD) || (op == OP_LR);
    req_wen[c] = (op == OP_WR) || (op == OP_SC);
    req_lr[c]  = (op == OP_LR);
    req_sc[c]  = (op == OP_SC);
    if (c == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
  endtask

  task automatic clear_core(input int c);
    req_ren[c] = 1'b0; req_wen[c] = 1'b0; req_lr[c] = 1'b0; req_sc[c] = 1'b0;
  endtask

  task automatic model_reset();
    ref_lv[0] = 1'b0; ref_lv[1] = 1'b0;
    ref_la[0] = '0;   ref_la[1] = '0;
    ref_last  = 1;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    clear_core(0); clear_core(1);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    model_reset();
  endtask

  // Issue requests from the cores in mask on the same cycle and check every completion.
  task automatic run_round(input logic [1:0] mask, input int op0, input logic [31:0] a0,
                           input logic [31:0] d0, input int op1, input logic [31:0] a1,
                           input logic [31:0] d1, input bit chk_gap);
    int ops [2]; logic [31:0] as [2]; logic [31:0] ds [2];
    int order [2]; logic [31:0] er [2]; int em [2]; int cyc_ack [2];
    int n, base; bit got;
    ops[0] = op0; as[0] = a0; ds[0] = d0;
    ops[1] = op1; as[1] = a1; ds[1] = d1;
    cyc_ack[0] = 0; cyc_ack[1] = 0;
    if (mask == 2'b11) begin
      order[0] = (ref_last == 0) ? 1 : 0;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = mask[1] ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    for (int k = 0; k < n; k++) begin
      model_exec(order[k], ops[order[k]], as[order[k]], ds[order[k]], er[k], em[k]);
      ref_last = order[k];
    end
    @(posedge CLK); #1;
    for (int c = 0; c < 2; c++) if (mask[c]) drive_core(c, ops[c], as[c], ds[c]);
    base = acc_count;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int c = 0; c < 64; c++) begin
        @(negedge CLK);
        if (ack != 2'b00) begin got = 1'b1; break; end
      end
      chk("ack_seen", 64'(got), 64'd1);
      if (got) begin
        $display("txn core=%0d op=%0d addr=%h ack=%b rdata=%h", order[k], ops[order[k]],
                 as[order[k]], ack, rdata);
        chk("ack_core", 64'(ack), 64'd1 << order[k]);
        chk("rdata", 64'(rdata), 64'(er[k]));
        chk("mem_access_count", 64'(acc_count - base), 64'(em[k] != 0));
        if (em[k] != 0) begin
          chk("mem_op_write", 64'(acc_write), 64'(em[k] == 2));
          chk("mem_addr", 64'(acc_addr), 64'(as[order[k]]));
          if (em[k] == 2) chk("mem_wdata", 64'(acc_wdata), 64'(ds[order[k]]));
        end
        cyc_ack[k] = cycle;
      end
      base = acc_count;
      @(posedge CLK); #1;
      clear_core(order[k]);
      @(negedge CLK);
      chk("ack_pulse_one_cycle", 64'(ack), 64'd0);
    end
    if (chk_gap && n == 2) chk("ack_gap_cycles", 64'(cyc_ack[1] - cyc_ack[0]), 64'd3);
  endtask

  task automatic one(input int core, input int op, input logic [31:0] a, input logic [31:0] d);
    if (core == 0) run_round(2'b01, op, a, d, OP_RD, '0, '0, 1'b0);
    else           run_round(2'b10, OP_RD, '0, '0, op, a, d, 1'b0);
  endtask

  initial begin
    int rb;
    bit got_ack;
    nRST = 1'b0;
    req_ren = '0; req_wen = '0; req_lr = '0; req_sc = '0;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    model_reset();
    ref_mem[30'h40] = 32'hDEADBEEF;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_ram_ren", 64'(ram_ren), 64'd0);
    chk("rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    nRST = 1'b1;

    // Read with two wait states
    wait_fixed = 2;
    rb = ren_cycles;
    one(0, OP_RD, 32'h100, 32'h0);
    chk("ren_high_cycles", 64'(ren_cycles - rb), 64'd3);

    // Simultaneous reads out of reset: core0 first, then alternation
    wait_fixed = 0;
    apply_reset();
    run_round(2'b11, OP_RD, 32'h104, '0, OP_RD, 32'h108, '0, 1'b1);
    run_round(2'b11, OP_RD, 32'h104, '0, OP_RD, 32'h108, '0, 1'b1);

    // LR then SC succeeds, repeated SC fails
    one(0, OP_LR, 32'h200, '0);
    one(0, OP_SC, 32'h200, 32'h5);
    one(0, OP_SC, 32'h200, 32'h6);
    one(0, OP_RD, 32'h200, '0);

    // Other core's store to the same word breaks the reservation
    one(0, OP_LR, 32'h300, '0);
    one(1, OP_WR, 32'h302, 32'hABCD1234);
    one(0, OP_SC, 32'h300, 32'h77);
    one(1, OP_RD, 32'h300, '0);

    // Store to a different word leaves the reservation intact
    one(1, OP_LR, 32'h400, '0);
    one(0, OP_WR, 32'h404, 32'h11112222);
    one(1, OP_SC, 32'h400, 32'h33334444);

    // Async reset in the middle of a long access
    one(0, OP_LR, 32'h500, '0);
    wait_fixed = 6;
    @(posedge CLK); #1;
    drive_core(0, OP_RD, 32'h104, '0);
    repeat (2) @(negedge CLK);
    chk("ren_mid_access", 64'(ram_ren), 64'd1);
    #2 nRST = 1'b0;
    #1;
    chk("ren_async_drop", 64'(ram_ren), 64'd0);
    chk("wen_async_drop", 64'(ram_wen), 64'd0);
    clear_core(0);
    got_ack = 1'b0;
    repeat (2) @(negedge CLK) if (ack != 2'b00) got_ack = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b1;
    model_reset();
    repeat (4) @(negedge CLK) if (ack != 2'b00) got_ack = 1'b1;
    chk("no_ack_after_abort", 64'(got_ack), 64'd0);
    wait_fixed = 0;
    run_round(2'b11, OP_RD, 32'h108, '0, OP_RD, 32'h10C, '0, 1'b1);
    one(0, OP_SC, 32'h500, 32'h99);

    // Random rounds over a few shared words
    wait_fixed = -1;
    for (int r = 0; r < 60; r++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      run_round(m,
                int'($urandom_range(0, 3)), 32'h600 + 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3)), $urandom,
                int'($urandom_range(0, 3)), 32'h600 + 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3)), $urandom,
                1'b0);
    end

    chk("protocol_errors", 64'(proto_err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
